clock_step_ctrl: RTL and testbench

CLOCK_STEP_CTRL -- requirements
Module: clock_step_ctrl

---
 rtl/clock_step_ctrl.sv | 127 ++++++++++++
 tb/tb_clock_step_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_ctrl.sv
// rtl/clock_step_ctrl.sv - tick generator with halt/run/single-step control
// Optional step-button debounce: define STEP_DEBOUNCE_EN.
module clock_step_ctrl #(
  parameter int DIV_W   = 23,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 4999999,
  parameter int DB_CYC  = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_val,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             step_req,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             running
);

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP_ARM,
    S_STEP_HOLD
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] per_cnt;
  logic             step_s1, step_s2, step_lvl, step_prev;
  logic             step_rise, terminal, tick_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_s1   <= step_req;
      step_s2   <= step_s1;
      step_prev <= step_lvl;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYC + 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  // Accept a new level only after it has differed from the held one for DB_CYC cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (step_s2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYC - 1)) begin
      db_level <= step_s2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign step_lvl = db_level;
`else
  assign step_lvl = step_s2;
`endif

  assign step_rise = step_lvl && !step_prev;
  assign terminal  = (per_cnt == div_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_HALT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tick_nx  = 1'b0;
    case (mode)
      2'b01: begin
        state_nx = S_RUN;
        tick_nx  = (state == S_RUN) && terminal;
      end
      2'b10: begin
        case (state)
          S_STEP_ARM: begin
            if (step_rise) begin
              state_nx = S_STEP_HOLD;
              tick_nx  = 1'b1;
            end
          end
          S_STEP_HOLD: if (!step_lvl) state_nx = S_STEP_ARM;
          default:     state_nx = S_STEP_ARM;
        endcase
      end
      default: state_nx = S_HALT;
    endcase
  end

  // A load restarts the period; a coincident terminal tick is still issued via tick_nx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= DIV_W'(DEF_DIV);
      per_cnt <= '0;
    end else begin
      if (load) div_reg <= div_val;
      if (load || state != S_RUN || mode != 2'b01 || terminal) per_cnt <= '0;
      else                                                     per_cnt <= per_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick <= tick_nx;
      if (tick_nx) tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign running = (state == S_RUN);

endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb/tb_clock_step_ctrl.sv - randomized self-checking bench for clock_step_ctrl
module tb_clock_step_ctrl;

  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int DEFD    = 6;
  localparam int CNT_MOD = 1 << CW;

  logic          clk;
  logic          reset;
  logic [DW-1:0] div_val;
  logic          load;
  logic [1:0]    mode;
  logic          step_req;
  logic          tick;
  logic [CW-1:0] tick_cnt;
  logic          running;

  clock_step_ctrl #(
    .DIV_W  (DW),
    .CNT_W  (CW),
    .DEF_DIV(DEFD),
    .DB_CYC (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .div_val (div_val),
    .load    (load),
    .mode    (mode),
    .step_req(step_req),
    .tick    (tick),
    .tick_cnt(tick_cnt),
    .running (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: RUN ticks are tracked as an absolute deadline edge number,
  // step ticks from the twice-delayed button level and an armed/held flag.
  int e, due, m_div, exp_cnt;
  bit in_run, in_step, holding, q1, q2, q3, exp_tick;

  task automatic model_reset();
    m_div    = DEFD;
    in_run   = 0;
    in_step  = 0;
    holding  = 0;
    q1       = 0;
    q2       = 0;
    q3       = 0;
    exp_tick = 0;
    exp_cnt  = 0;
    due      = 0;
  endtask

  task automatic model_edge();
    bit rise;
    rise     = q2 && !q3;
    e++;
    exp_tick = 0;
    if (mode == 2'b01) begin
      if (in_run && e == due) begin
        exp_tick = 1;
        due      = e + m_div + 1;
      end
      if (load) begin
        m_div = int'(div_val);
        due   = e + m_div + 1;
      end else if (!in_run) begin
        due = e + m_div + 1;
      end
    end else if (load) begin
      m_div = int'(div_val);
    end
    if (mode == 2'b10) begin
      if (!in_step) begin
        in_step = 1;
        holding = 0;
      end else if (!holding && rise) begin
        exp_tick = 1;
        holding  = 1;
      end else if (holding && !q2) begin
        holding = 0;
      end
    end else begin
      in_step = 0;
      holding = 0;
    end
    in_run = (mode == 2'b01);
    if (exp_tick) exp_cnt = (exp_cnt + 1) % CNT_MOD;
    q3 = q2;
    q2 = q1;
    q1 = step_req;
  endtask

  task automatic cyc(input logic [1:0] m, input logic ld, input logic [DW-1:0] dv, input logic sr);
    mode     = m;
    load     = ld;
    div_val  = dv;
    step_req = sr;
    @(posedge clk);
    model_edge();
    #1;
    check("tick", 32'(tick), 32'(exp_tick));
    check("tick_cnt", 32'(tick_cnt), 32'(exp_cnt));
    check("running", 32'(running), 32'(in_run));
  endtask

  // Called at posedge+1: asserts reset between edges and holds it across one edge.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_tick_cnt", 32'(tick_cnt), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_tick", 32'(tick), 32'd0);
    #1;
    reset = 1'b0;
  endtask

  int         nt, pos;
  logic [1:0] cur_m;
  logic       cur_s, ld;
  logic [DW-1:0] dv;

  initial begin
    reset    = 1'b1;
    mode     = 2'b00;
    load     = 1'b0;
    div_val  = '0;
    step_req = 1'b0;
    e        = 0;
    model_reset();
    #12;
    check("init_tick", 32'(tick), 32'd0);
    check("init_tick_cnt", 32'(tick_cnt), 32'd0);
    check("init_running", 32'(running), 32'd0);
    #1;
    reset = 1'b0;

`ifdef STEP_DEBOUNCE_EN
    mode = 2'b10;
    nt   = 0;
    for (int i = 0; i < 33; i++) begin
      step_req = (i >= 3 && i < 8);
      @(posedge clk);
      #1;
      if (tick) nt++;
    end
    check("db_glitch_ticks", 32'(nt), 32'd0);
    nt = 0;
    for (int i = 0; i < 32; i++) begin
      step_req = (i < 12);
      @(posedge clk);
      #1;
      if (tick) nt++;
    end
    check("db_press_ticks", 32'(nt), 32'd1);
    step_req = 1'b0;
    async_reset();
`endif

    // Run at div 3 from entry: ticks every 4 cycles.
    cyc(2'b01, 1'b1, 8'd3, 1'b0);
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(2'b01, 1'b0, 8'd0, 1'b0);
      if (tick) nt++;
    end
    check("run4_ticks", 32'(nt), 32'd3);
    check("run4_cnt", 32'(tick_cnt), 32'd3);
    check("run4_running", 32'(running), 32'd1);

    // Reload mid-period at counter 5 with div 9 -> 1.
    async_reset();
    cyc(2'b01, 1'b1, 8'd9, 1'b0);
    for (int i = 0; i < 5; i++) cyc(2'b01, 1'b0, 8'd0, 1'b0);
    cyc(2'b01, 1'b1, 8'd1, 1'b0);
    cyc(2'b01, 1'b0, 8'd0, 1'b0);
    check("reload_early", 32'(tick), 32'd0);
    cyc(2'b01, 1'b0, 8'd0, 1'b0);
    check("reload_tick", 32'(tick), 32'd1);

    // Tick every cycle, counter wraps through zero.
    async_reset();
    cyc(2'b01, 1'b1, 8'd0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cyc(2'b01, 1'b0, 8'd0, 1'b0);
      if (i == 16) check("wrap_zero", 32'(tick_cnt), 32'd0);
    end
    check("wrap_end", 32'(tick_cnt), 32'd1);

    // Reset default divide: first tick DEFD+1 cycles after entry.
    async_reset();
    cyc(2'b01, 1'b0, 8'd0, 1'b0);
    pos = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(2'b01, 1'b0, 8'd0, 1'b0);
      if (tick && pos < 0) pos = i;
    end
    check("def_div_first", 32'(pos), 32'(DEFD + 1));

    // Cancel pending tick: leave RUN on the terminal edge.
    async_reset();
    cyc(2'b01, 1'b1, 8'd2, 1'b0);
    cyc(2'b01, 1'b0, 8'd0, 1'b0);
    cyc(2'b01, 1'b0, 8'd0, 1'b0);
    cyc(2'b00, 1'b0, 8'd0, 1'b0);
    check("cancel_tick", 32'(tick), 32'd0);

`ifndef STEP_DEBOUNCE_EN
    // Single step: held button yields one tick, two edges after first sample.
    async_reset();
    for (int i = 0; i < 3; i++) cyc(2'b10, 1'b0, 8'd0, 1'b0);
    nt  = 0;
    pos = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(2'b10, 1'b0, 8'd0, 1'b1);
      if (tick) begin
        nt++;
        if (pos < 0) pos = i;
      end
    end
    check("step_ticks", 32'(nt), 32'd1);
    check("step_latency", 32'(pos), 32'd2);
    for (int i = 0; i < 5; i++) cyc(2'b10, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(2'b10, 1'b0, 8'd0, 1'b1);
    check("step_second", 32'(tick_cnt), 32'd2);
    cyc(2'b00, 1'b0, 8'd0, 1'b0);
`endif

    cur_m = 2'b01;
    cur_s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cur_s = ~cur_s;
`ifdef STEP_DEBOUNCE_EN
      cur_s = 1'b0;
`endif
      ld = ($urandom_range(0, 29) == 0);
      dv = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) async_reset();
      cyc(cur_m, ld, dv, cur_s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
